// File: rtl/start_stop_seq_pkg.sv
// rtl/start_stop_seq_pkg.sv - shared types, default constants and wrap helper for start_stop_seq
//   Contents: state_t (IDLE/START/RUN/STOP/DONE, 3-bit), DEF_LEN_W, DEF_MOD, DEF_CNT_W,
//   next_mod(cnt, modulus) -> cnt+1 with wrap from modulus-1 to 0.
package start_stop_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_RUN   = 3'd2,
    ST_STOP  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam int unsigned DEF_LEN_W = 8;
  localparam int unsigned DEF_MOD   = 14;
  localparam int unsigned DEF_CNT_W = 4;

  // Compare against the last legal value before incrementing, so the
  // result never leaves 0..modulus-1.
  function automatic int unsigned next_mod(input int unsigned cnt, input int unsigned modulus);
    return (cnt == modulus - 1) ? 32'd0 : cnt + 32'd1;
  endfunction

endpackage

// File: rtl/start_stop_seq_mod_cnt_mirror.sv
// rtl/start_stop_seq_mod_cnt_mirror.sv - mirror of the downstream mod-N run counter
//   Ports: clk, reset (async, active-high), start / stop (1-cycle pulses),
//   exp_count [CNT_W] (expected downstream count value).
//   Params: MOD (modulus), CNT_W (count width, 2**CNT_W >= MOD).
module mod_cnt_mirror
  import start_stop_seq_pkg::*;
#(
  parameter int unsigned MOD   = DEF_MOD,
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  output logic [CNT_W-1:0] exp_count
);

  logic en_mirror;

  // Behaves exactly like the downstream counter: enabled from the edge that
  // sees start until the edge that sees stop, counting on every enabled edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      en_mirror <= 1'b0;
      exp_count <= '0;
    end else begin
      if (start) begin
        en_mirror <= 1'b1;
      end else if (stop) begin
        en_mirror <= 1'b0;
      end
      if (en_mirror) begin
        exp_count <= CNT_W'(next_mod(32'(exp_count), MOD));
      end
    end
  end

endmodule

// File: rtl/start_stop_seq.sv
// rtl/start_stop_seq.sv - command-driven start/stop pulse initiator for the mod-N run counter
//   Ports: clk, reset (async, active-high), cmd_valid/cmd_ready/cmd_len [LEN_W] (command
//   handshake), start, stop, done (1-cycle pulses), busy, exp_count [CNT_W] (mirror value).
//   Optional (macro SSEQ_ABORT_EN): abort in (early stop request), aborted out (qualifies done).
//   Params: LEN_W, MOD, CNT_W.
module start_stop_seq
  import start_stop_seq_pkg::*;
#(
  parameter int unsigned LEN_W = DEF_LEN_W,
  parameter int unsigned MOD   = DEF_MOD,
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [LEN_W-1:0] cmd_len,
  output logic             start,
  output logic             stop,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] exp_count
`ifdef SSEQ_ABORT_EN
  ,
  input  logic             abort,
  output logic             aborted
`endif
);

  state_t           state, state_n;
  logic [LEN_W-1:0] cnt, cnt_n;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // cnt holds the latched length while in START, then doubles as the RUN
  // down-counter (loaded with L-2 so RUN lasts L-1 cycles).
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      ST_IDLE: begin
        if (cmd_valid) begin
          if (cmd_len == '0) begin
            state_n = ST_DONE;
          end else begin
            state_n = ST_START;
            cnt_n   = cmd_len;
          end
        end
      end
      ST_START: begin
        if (cnt == LEN_W'(1)) begin
          state_n = ST_STOP;
        end else begin
          state_n = ST_RUN;
          cnt_n   = cnt - LEN_W'(2);
        end
      end
      ST_RUN: begin
        if (cnt == '0) begin
          state_n = ST_STOP;
        end else begin
          cnt_n = cnt - LEN_W'(1);
        end
      end
      ST_STOP: state_n = ST_DONE;
      ST_DONE: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
`ifdef SSEQ_ABORT_EN
    if ((state == ST_START || state == ST_RUN) && abort) begin
      state_n = ST_STOP;
    end
`endif
  end

  assign cmd_ready = (state == ST_IDLE);
  assign start     = (state == ST_START);
  assign stop      = (state == ST_STOP);
  assign done      = (state == ST_DONE);
  assign busy      = (state != ST_IDLE);

`ifdef SSEQ_ABORT_EN
  logic abort_seen;

  // Remembers that this run was cut short so aborted can be decoded with done.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      abort_seen <= 1'b0;
    end else if (state == ST_IDLE) begin
      abort_seen <= 1'b0;
    end else if ((state == ST_START || state == ST_RUN) && abort) begin
      abort_seen <= 1'b1;
    end
  end

  assign aborted = (state == ST_DONE) && abort_seen;
`endif

  mod_cnt_mirror #(
    .MOD   (MOD),
    .CNT_W (CNT_W)
  ) u_mirror (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .stop      (stop),
    .exp_count (exp_count)
  );

endmodule

// File: tb/tb_start_stop_seq.sv
// tb/tb_start_stop_seq.sv - self-checking bench for start_stop_seq against a cycle-event model
//   Drives directed and $urandom commands; define SSEQ_ABORT_EN to exercise abort/aborted.
module tb_start_stop_seq;

  localparam int MODV = 14;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [7:0] cmd_len = 8'd0;
  logic       start, stop, busy, done;
  logic [3:0] exp_count;
`ifdef SSEQ_ABORT_EN
  logic       abort = 1'b0;
  logic       aborted;
`endif

  int checks = 0;
  int failures = 0;
  int base = 0;

  always #5 clk = ~clk;

  start_stop_seq dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_len   (cmd_len),
    .start     (start),
    .stop      (stop),
    .busy      (busy),
    .done      (done),
    .exp_count (exp_count)
`ifdef SSEQ_ABORT_EN
    ,
    .abort     (abort),
    .aborted   (aborted)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      failures++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Model: a run of effective length le (L, or the abort cycle if earlier)
  // shows start in C1, stop in C(le+1), done in C(le+2); L=0 shows only done in C1.
  // The counter has seen clamp(k-2, 0, le) increments by cycle Ck.
  task automatic run_cmd(input int len, input int abort_at);
    int  le, n, inc;
    bit  hit;
    hit = (len > 0) && (abort_at >= 1) && (abort_at <= len);
    le  = hit ? abort_at : len;
    n   = (len == 0) ? 1 : le + 2;
    @(negedge clk);
    check("ready_before_cmd", cmd_ready, 1);
    check("busy_before_cmd", busy, 0);
    check("count_before_cmd", exp_count, base);
    cmd_valid = 1'b1;
    cmd_len   = len[7:0];
    @(posedge clk);
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      inc = (k - 2 < 0) ? 0 : ((k - 2 > le) ? le : k - 2);
      check("start", start, (len > 0) && (k == 1));
      check("stop", stop, (len > 0) && (k == le + 1));
      check("done", done, k == n);
      check("busy", busy, 1);
      check("ready_in_run", cmd_ready, 0);
      check("count_in_run", exp_count, (base + inc) % MODV);
`ifdef SSEQ_ABORT_EN
      check("aborted", aborted, hit && (k == n));
      abort = (k == abort_at) || ((k > le) && ($urandom_range(0, 1) == 1));
`endif
      // Commands offered while busy must be ignored.
      cmd_valid = ($urandom_range(0, 1) == 1);
      cmd_len   = 8'($urandom);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
`ifdef SSEQ_ABORT_EN
    abort = 1'b0;
`endif
    base = (base + le) % MODV;
    check("ready_after", cmd_ready, 1);
    check("busy_after", busy, 0);
    check("done_after", done, 0);
    check("count_after", exp_count, base);
  endtask

  initial begin
    int len, ab;
    #1;
    check("rst_ready", cmd_ready, 1);
    check("rst_start", start, 0);
    check("rst_stop", stop, 0);
    check("rst_done", done, 0);
    check("rst_busy", busy, 0);
    check("rst_count", exp_count, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    run_cmd(5, 0);
    check("t1_count", exp_count, 5);
    run_cmd(1, 0);
    check("t2_count", exp_count, 6);
    run_cmd(0, 0);
    check("t3_count", exp_count, 6);
    run_cmd(4, 0);
    run_cmd(20, 0);
    check("t4_wrap_count", exp_count, 2);

    // Reset in the middle of a 9-long run.
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_len   = 8'd9;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("pre_rst_busy", busy, 1);
    #2 reset = 1'b1;
    #1;
    check("midrst_start", start, 0);
    check("midrst_stop", stop, 0);
    check("midrst_done", done, 0);
    check("midrst_busy", busy, 0);
    check("midrst_ready", cmd_ready, 1);
    check("midrst_count", exp_count, 0);
    @(negedge clk);
    reset = 1'b0;
    base  = 0;
    repeat (2) begin
      @(negedge clk);
      check("postrst_ready", cmd_ready, 1);
      check("postrst_stop", stop, 0);
      check("postrst_count", exp_count, 0);
    end

`ifdef SSEQ_ABORT_EN
    run_cmd(9, 3);
    check("t6_count", exp_count, 3);
    run_cmd(1, 1);
    run_cmd(6, 1);
`endif

    run_cmd(255, 0);
    run_cmd(2, 0);

    repeat (25) begin
      len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 2)) : int'($urandom_range(3, 40));
      ab  = 0;
`ifdef SSEQ_ABORT_EN
      if ($urandom_range(0, 1) == 1) ab = int'($urandom_range(1, len + 2));
`endif
      run_cmd(len, ab);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
